hsem_ahb_master: RTL

HSEM_AHB_MASTER -- requirements
Module: hsem_ahb_master

---
 rtl/hsem_ahb_master.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/hsem_ahb_master.sv
// Single-outstanding AHB-Lite initiator issuing word-sized SINGLE NONSEQ transfers.
// Optional macro HSEM_MST_RETRY_EN re-issues ERROR transfers up to RETRY_MAX times.
module hsem_ahb_master #(
    parameter int unsigned RETRY_MAX = 2
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic        hmastlock,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic [1:0]  hresp
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR2 = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    assign hsize     = 3'b010;
    assign hburst    = 3'b000;
    assign hprot     = 4'b0011;
    assign hmastlock = 1'b0;

    logic [2:0]  state, state_n;
    logic [31:0] wdata_q, wdata_n;
    logic [31:0] haddr_n, hwdata_n, rsp_rdata_n;
    logic [1:0]  htrans_n;
    logic        hwrite_n, cmd_ready_n, rsp_valid_n, rsp_err_n;
    logic        done_ok, done_err;

`ifdef HSEM_MST_RETRY_EN
    localparam int unsigned CNT_W = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX + 1);
    logic [CNT_W-1:0] retry_cnt, retry_cnt_n;
`endif

    // Next-state and next-output logic; haddr/hwrite double as the latched command.
    always_comb begin
        state_n     = state;
        haddr_n     = haddr;
        hwrite_n    = hwrite;
        wdata_n     = wdata_q;
        rsp_rdata_n = rsp_rdata;
        rsp_err_n   = rsp_err;
        done_ok     = 1'b0;
        done_err    = 1'b0;
`ifdef HSEM_MST_RETRY_EN
        retry_cnt_n = retry_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    haddr_n  = {cmd_addr[31:2], 2'b00};
                    hwrite_n = cmd_write;
                    wdata_n  = cmd_wdata;
                    state_n  = ST_ADDR;
`ifdef HSEM_MST_RETRY_EN
                    retry_cnt_n = '0;
`endif
                end
            end
            ST_ADDR: begin
                if (hready) state_n = ST_DATA;
            end
            ST_DATA: begin
                if (hresp == HRESP_ERROR) begin
                    if (hready) done_err = 1'b1;
                    else        state_n  = ST_ERR2;
                end else if (hready) begin
                    done_ok = 1'b1;
                end
            end
            ST_ERR2: begin
                if (hready) done_err = 1'b1;
            end
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        if (done_ok) begin
            state_n   = ST_RESP;
            rsp_err_n = 1'b0;
            if (!hwrite) rsp_rdata_n = hrdata;
        end

        if (done_err) begin
`ifdef HSEM_MST_RETRY_EN
            if (retry_cnt < CNT_W'(RETRY_MAX)) begin
                retry_cnt_n = retry_cnt + CNT_W'(1);
                state_n     = ST_ADDR;
            end else begin
                state_n   = ST_RESP;
                rsp_err_n = 1'b1;
            end
`else
            state_n   = ST_RESP;
            rsp_err_n = 1'b1;
`endif
        end

        cmd_ready_n = (state_n == ST_IDLE);
        rsp_valid_n = (state_n == ST_RESP);
        htrans_n    = (state_n == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        hwdata_n    = ((state_n == ST_DATA || state_n == ST_ERR2) && hwrite_n) ? wdata_n : 32'd0;
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state     <= ST_IDLE;
            wdata_q   <= 32'd0;
            haddr     <= 32'd0;
            hwrite    <= 1'b0;
            htrans    <= HTRANS_IDLE;
            hwdata    <= 32'd0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            wdata_q   <= wdata_n;
            haddr     <= haddr_n;
            hwrite    <= hwrite_n;
            htrans    <= htrans_n;
            hwdata    <= hwdata_n;
            cmd_ready <= cmd_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_err   <= rsp_err_n;
        end
    end

`ifdef HSEM_MST_RETRY_EN
    always_ff @(posedge hclk) begin
        if (!hresetn) retry_cnt <= '0;
        else          retry_cnt <= retry_cnt_n;
    end
`endif

endmodule
